// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the core (port 0, priority) and the loader (port 1).
// One transaction at a time: IDLE sample, LAT ACCESS cycles, one DONE cycle with a per-port done pulse.
module mem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int LAT        = 2,
   parameter int MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              done0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int STK_W = $clog2(MAX_STREAK + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAT - 1);
   localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state;
   logic              owner;
   logic              we_q;
   logic [CNT_W-1:0]  lat_cnt;
   logic [STK_W-1:0]  streak;

   logic              grant1;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   // Loader wins when alone, or when the core has used up its streak while the loader waited.
   assign grant1    = req1 && (!req0 || streak == STK_MAX);
   assign win_we    = grant1 ? we1    : we0;
   assign win_addr  = grant1 ? addr1  : addr0;
   assign win_wdata = grant1 ? wdata1 : wdata0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         we_q      <= 1'b0;
         lat_cnt   <= '0;
         streak    <= '0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         rdata     <= '0;
         busy      <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!req1 || grant1)
                  streak <= '0;
               else if (streak != STK_MAX)
                  streak <= streak + STK_W'(1);
               if (req0 || req1) begin
                  owner     <= grant1;
                  we_q      <= win_we;
                  mem_addr  <= win_addr;
                  mem_wdata <= win_wdata;
                  mem_en    <= 1'b1;
                  mem_we    <= win_we;
                  busy      <= 1'b1;
                  lat_cnt   <= '0;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               // Write strobe lives for the first access cycle only.
               mem_we  <= 1'b0;
               lat_cnt <= lat_cnt + CNT_W'(1);
               if (lat_cnt == LAST_CNT) begin
                  if (!we_q)
                     rdata <= mem_rdata;
                  mem_en <= 1'b0;
                  done0  <= ~owner;
                  done1  <= owner;
                  state  <= DONE;
               end
            end
            DONE: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: transaction-level model predicts grant order, timing and data.
module tb_mem_port_arbiter;
   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 16;
   localparam int LAT        = 2;
   localparam int MAX_STREAK = 4;
   localparam int TMO        = 200;

   logic clk = 1'b0;
   logic rst, rst_s;
   always #5 clk = ~clk;

   logic              req0, we0, req1, we1, done0, done1, busy, mem_en, mem_we;
   logic [ADDR_W-1:0] addr0, addr1, mem_addr;
   logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT), .MAX_STREAK(MAX_STREAK)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
      .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   logic [DATA_W-1:0] tb_mem  [256];
   logic [DATA_W-1:0] ref_mem [256];
   assign mem_rdata = tb_mem[mem_addr];
   always @(posedge clk) if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;

   // Latency sweep instances: core reads held continuously, memory returns a function of the address.
   logic              s_req;
   logic              zero_b = 1'b0;
   logic [ADDR_W-1:0] zero_a = '0;
   logic [DATA_W-1:0] zero_d = '0;
   logic [ADDR_W-1:0] l1_ain = 8'h30, l4_ain = 8'h70;
   logic              l1_d0, l1_d1, l1_busy, l1_en, l1_we, l4_d0, l4_d1, l4_busy, l4_en, l4_we;
   logic [ADDR_W-1:0] l1_maddr, l4_maddr;
   logic [DATA_W-1:0] l1_rdata, l1_mwd, l1_mrd, l4_rdata, l4_mwd, l4_mrd;
   assign l1_mrd = {l1_maddr, ~l1_maddr};
   assign l4_mrd = {l4_maddr, ~l4_maddr};

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(1), .MAX_STREAK(MAX_STREAK)) u_lat1 (
      .clk(clk), .rst(rst_s),
      .req0(s_req), .we0(zero_b), .addr0(l1_ain), .wdata0(zero_d), .done0(l1_d0),
      .req1(zero_b), .we1(zero_b), .addr1(zero_a), .wdata1(zero_d), .done1(l1_d1),
      .rdata(l1_rdata), .busy(l1_busy), .mem_en(l1_en), .mem_we(l1_we),
      .mem_addr(l1_maddr), .mem_wdata(l1_mwd), .mem_rdata(l1_mrd));

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(4), .MAX_STREAK(MAX_STREAK)) u_lat4 (
      .clk(clk), .rst(rst_s),
      .req0(s_req), .we0(zero_b), .addr0(l4_ain), .wdata0(zero_d), .done0(l4_d0),
      .req1(zero_b), .we1(zero_b), .addr1(zero_a), .wdata1(zero_d), .done1(l4_d1),
      .rdata(l4_rdata), .busy(l4_busy), .mem_en(l4_en), .mem_we(l4_we),
      .mem_addr(l4_maddr), .mem_wdata(l4_mwd), .mem_rdata(l4_mrd));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      int                port;
      int                cyc;
      logic [DATA_W-1:0] rdata;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } exp_t;

   exp_t expq[$];
   int   done_log[$];

   // Transaction-level reference: when the arbiter is free, pick the winner and predict the result.
   int                next_idle = 0;
   int                m_streak  = 0;
   logic [DATA_W-1:0] m_rdata   = '0;
   logic              hold0, hold1;

   task automatic model_step();
      exp_t e;
      int   win;
      if (rst) begin
         next_idle = cyc + 1;
         m_streak  = 0;
         m_rdata   = '0;
         return;
      end
      if (cyc < next_idle) return;
      if (!req0 && !req1) begin
         m_streak  = 0;
         next_idle = cyc + 1;
         return;
      end
      win = (req0 && !(req1 && m_streak == MAX_STREAK)) ? 0 : 1;
      if (!req1 || win == 1) m_streak = 0;
      else if (m_streak < MAX_STREAK) m_streak++;
      e.port  = win;
      e.cyc   = cyc + LAT + 1;
      e.we    = win ? we1 : we0;
      e.addr  = win ? addr1 : addr0;
      e.wdata = win ? wdata1 : wdata0;
      if (e.we) ref_mem[e.addr] = e.wdata;
      else      m_rdata = ref_mem[e.addr];
      e.rdata = m_rdata;
      expq.push_back(e);
      next_idle = cyc + LAT + 2;
   endtask

   task automatic set_req(input int p, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (p == 0) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
      else        begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
   endtask

   task automatic rand_req(input int p);
      set_req(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
   endtask

   task automatic handle_drops();
      if (done0) begin if (hold0) rand_req(0); else req0 = 1'b0; end
      if (done1) begin if (hold1) rand_req(1); else req1 = 1'b0; end
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
      handle_drops();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((expq.size() != 0 || req0 || req1 || cyc < next_idle) && n < TMO) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(n >= TMO), 0);
   endtask

   // Monitor: compares every done pulse against the oldest predicted transaction.
   int                en_cnt = 0, we_cnt = 0;
   logic [ADDR_W-1:0] first_addr;
   logic [DATA_W-1:0] first_wdata;
   exp_t              mon_e;

   always @(negedge clk) begin
      if (rst) begin
         en_cnt = 0;
         we_cnt = 0;
      end else begin
         if (mem_en) begin
            if (en_cnt == 0) begin first_addr = mem_addr; first_wdata = mem_wdata; end
            en_cnt++;
            if (mem_we) we_cnt++;
         end
         if (done0 || done1) begin
            chk("done_exclusive", 32'(done0 && done1), 0);
            done_log.push_back(done1 ? 1 : 0);
            if (expq.size() == 0) begin
               chk("done_without_pending_txn", 32'({done1, done0}), 0);
            end else begin
               mon_e = expq.pop_front();
               chk("done_port",      done1 ? 1 : 0, 32'(mon_e.port));
               chk("done_cycle",     32'(cyc), 32'(mon_e.cyc));
               chk("rdata",          32'(rdata), 32'(mon_e.rdata));
               chk("access_cycles",  32'(en_cnt), LAT);
               chk("write_strobes",  32'(we_cnt), 32'(mon_e.we));
               chk("mem_addr",       32'(first_addr), 32'(mon_e.addr));
               if (mon_e.we) chk("mem_wdata", 32'(first_wdata), 32'(mon_e.wdata));
               chk("busy_in_done",   32'(busy), 1);
               chk("mem_en_in_done", 32'(mem_en), 0);
            end
            en_cnt = 0;
            we_cnt = 0;
         end
      end
   end

   int s_start = 0;
   int l1_next = 0, l4_next = 0, l1_cnt = 0, l4_cnt = 0;

   always @(negedge clk) begin
      if (!rst_s && l1_d0) begin
         if (l1_cnt == 0) l1_next = s_start + 2;
         chk("lat1_done_cycle", 32'(cyc), 32'(l1_next));
         chk("lat1_rdata", 32'(l1_rdata), 32'({l1_ain, ~l1_ain}));
         chk("lat1_done1", 32'(l1_d1), 0);
         l1_next = l1_next + 3;
         l1_cnt++;
         l1_ain++;
      end
      if (!rst_s && l4_d0) begin
         if (l4_cnt == 0) l4_next = s_start + 5;
         chk("lat4_done_cycle", 32'(cyc), 32'(l4_next));
         chk("lat4_rdata", 32'(l4_rdata), 32'({l4_ain, ~l4_ain}));
         l4_next = l4_next + 6;
         l4_cnt++;
         l4_ain++;
      end
   end

   initial begin
      int base;
      rst = 1'b1; rst_s = 1'b1; s_req = 1'b0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      hold0 = 1'b0; hold1 = 1'b0;
      for (int i = 0; i < 256; i++) begin
         tb_mem[i]  = 16'($urandom);
         ref_mem[i] = tb_mem[i];
      end
      tb_mem[8'h10]  = 16'hBEEF;
      ref_mem[8'h10] = 16'hBEEF;

      repeat (3) tick();
      chk("rst_done0", 32'(done0), 0);
      chk("rst_done1", 32'(done1), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);

      rst = 1'b0; rst_s = 1'b0; s_start = cyc; s_req = 1'b1;

      // Core read, loader write then core read-back, simultaneous requests.
      set_req(0, 1'b0, 8'h10, 16'h0);
      drain();
      set_req(1, 1'b1, 8'h05, 16'h1234);
      drain();
      set_req(0, 1'b0, 8'h05, 16'h0);
      drain();
      set_req(0, 1'b0, 8'($urandom_range(0, 15)), 16'h0);
      set_req(1, 1'b0, 8'($urandom_range(0, 15)), 16'h0);
      drain();

      // Both ports held: the fifth completion must belong to the loader.
      base = done_log.size();
      hold0 = 1'b1; hold1 = 1'b1;
      set_req(0, 1'b0, 8'h10, 16'h0);
      set_req(1, 1'b0, 8'h11, 16'h0);
      repeat (8 * (LAT + 2)) tick();
      hold0 = 1'b0; hold1 = 1'b0;
      drain();
      chk("starve_enough_dones", 32'(done_log.size() >= base + 6), 1);
      if (done_log.size() >= base + 6)
         for (int i = 0; i < 6; i++) chk("starve_order", 32'(done_log[base+i]), (i == 4) ? 1 : 0);

      // Reset in the second access cycle of a core read.
      set_req(0, 1'b0, 8'h10, 16'h0);
      tick();
      tick();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      expq.delete();
      tick();
      chk("abort_mem_en", 32'(mem_en), 0);
      chk("abort_mem_we", 32'(mem_we), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_rdata", 32'(rdata), 0);
      chk("abort_done0", 32'(done0), 0);
      tick();
      chk("abort_done0_late", 32'(done0), 0);
      rst = 1'b0;
      set_req(0, 1'b0, 8'h10, 16'h0);
      drain();

      for (int k = 0; k < 3000; k++) begin
         if (k % 250 == 0) begin
            hold0 = ($urandom_range(0, 3) == 0);
            hold1 = ($urandom_range(0, 3) == 0);
         end
         if (!req0 && $urandom_range(0, 2) == 0) rand_req(0);
         if (!req1 && $urandom_range(0, 4) == 0) rand_req(1);
         tick();
      end
      hold0 = 1'b0; hold1 = 1'b0;
      drain();

      chk("queue_empty", 32'(expq.size()), 0);
      chk("lat1_progress", 32'(l1_cnt >= 50), 1);
      chk("lat4_progress", 32'(l4_cnt >= 50), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the multicycle core (port 0) and the program loader/debug port (port 1).
- Serialises whole transactions and holds a fixed LAT-cycle access window per transaction.
- Reports completion per port, so the core controller stalls its fetch/MEM states until its own done pulse.
- Core has priority; a streak limit prevents loader starvation.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- LAT, 2, memory access cycles per transaction (>=1)
- MAX_STREAK, 4, consecutive core grants allowed while loader waits (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0  in  1  core request, held until done0
- we0  in  1  core write enable (1=write), held with req0
- addr0  in  ADDR_W  core address, held with req0
- wdata0  in  DATA_W  core write data, held with req0
- done0  out  1  one-cycle pulse: core transaction complete
- req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  loader request set, same rules as port 0
- done1  out  1  one-cycle pulse: loader transaction complete
- rdata  out  DATA_W  read data of last completed transaction, valid with done pulse, held until next capture
- busy  out  1  high in ACCESS and DONE states
- mem_en  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in last ACCESS cycle

Behaviour:
- Reset values: done0=done1=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; state=IDLE, owner=0, streak=0, lat_cnt=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - no req → stay in IDLE.
  - any req → register owner, addr/wdata/we of the winner; next state ACCESS, lat_cnt=0.
- Arbitration in IDLE:
  - only req0 → core wins.
  - only req1 → loader wins.
  - both, streak<MAX_STREAK → core wins.
  - both, streak==MAX_STREAK → loader wins.
- Streak counter:
  - core grant while req1 high → streak+1, saturating at MAX_STREAK.
  - loader grant, or req1 low in IDLE → streak=0.
- ACCESS (LAT cycles):
  - mem_en=1; mem_addr/mem_wdata driven from latched values.
  - mem_we=1 only in the first ACCESS cycle, and only for writes.
  - lat_cnt increments each cycle.
  - at lat_cnt==LAT-1, reads capture mem_rdata into rdata; writes leave rdata unchanged. Next state DONE.
- DONE (1 cycle):
  - mem_en=0; done<owner>=1.
  - next state IDLE.
- Latency: req sampled in IDLE at cycle 0; ACCESS cycles 1..LAT; done pulse at cycle LAT+1. Back-to-back throughput is LAT+2 cycles per transaction.
- Requester obligations:
  - drop req in the cycle done is high.
  - req still high in the following IDLE cycle = new transaction.
- Request inputs are ignored outside IDLE. Dropping req mid-transaction does not abort it; the done pulse still occurs.
- done0 and done1 are never high together. At most one transaction is in flight.
- Reset mid-ACCESS/DONE: return to IDLE next cycle; no done pulse; mem_en/mem_we=0; rdata=0.
- LAT=1: ACCESS lasts one cycle, with mem_we and capture in that same cycle.

Test Plan:
- Core read, LAT=2, addr0=0x10, mem holds 0xBEEF: req0 at cycle 0 → mem_en cycles 1–2, mem_we=0, done0 at cycle 3, rdata=0xBEEF, done1 never.
- Loader write addr1=0x05, wdata1=0x1234: mem_we high only in cycle 1; done1 at cycle 3; subsequent core read of 0x05 returns 0x1234; rdata unchanged by the write.
- req0 and req1 asserted together in IDLE: core served first (done0 at cycle 3); loader granted in the next IDLE cycle (done1 at cycle 7).
- Starvation: req0 held continuously, req1 held from cycle 0, MAX_STREAK=4 → four core transactions, then a loader transaction (5th done is done1), then core resumes.
- Reset at cycle 2 of a core read: mem_en=0 from cycle 3; no done0; busy=0; rdata=0; next req0 completes normally.
- Parameter sweep LAT=1 and LAT=4: done at cycle LAT+1 with correct rdata; back-to-back core reads complete every LAT+2 cycles.
